// File: rtl/m_udp_pingpong_buf_if.sv
// Bus bundle between the UDP RX/TX engines and the ping-pong packet buffer.
// master = RX/TX engine side, slave = buffer side.
interface m_udp_pingpong_buf_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic [AW-1:0] rx_addr;
  logic          rx_done;
  logic [15:0]   rx_data_length;
  logic [15:0]   rx_total_length;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          tx_req;
  logic          tx_start;
  logic          tx_done;
  logic [15:0]   tx_data_length;
  logic [15:0]   tx_total_length;
  logic          drop_pulse;

  modport master (
    output rx_valid, rx_data, rx_addr, rx_done, rx_data_length, rx_total_length,
    output rd_addr, tx_start, tx_done,
    input  rd_data, tx_req, tx_data_length, tx_total_length, drop_pulse
  );

  modport slave (
    input  rx_valid, rx_data, rx_addr, rx_done, rx_data_length, rx_total_length,
    input  rd_addr, tx_start, tx_done,
    output rd_data, tx_req, tx_data_length, tx_total_length, drop_pulse
  );
endinterface

// File: rtl/m_udp_pingpong_buf.sv
// Two-bank ping-pong frame buffer for UDP loopback on the 100M path.
// RX writes payload words into wr_bank; complete frames are offered to TX
// in arrival order via rd_bank. Lengths travel with each bank.
// Optional: define M_UDP_BUF_STATS_EN to add saturating frame_cnt/drop_cnt.
module m_udp_pingpong_buf #(
  parameter int AW      = 9,
  parameter int DW      = 32,
  parameter int MIN_LEN = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  m_udp_pingpong_buf_if.slave bus
`ifdef M_UDP_BUF_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
`endif
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_SENDING} bank_st_e;

  bank_st_e    st_q [2];
  bank_st_e    st_d [2];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic        noroom_q, noroom_d;
  logic [15:0] dlen_q [2];
  logic [15:0] dlen_d [2];
  logic [15:0] tlen_q [2];
  logic [15:0] tlen_d [2];
  logic        tx_req_q, tx_req_d;
  logic [15:0] tx_dlen_q, tx_dlen_d;
  logic [15:0] tx_tlen_q, tx_tlen_d;
  logic        drop_q, drop_d;
  logic [DW-1:0] rd_data_q;
  logic        wr_ok, wr_en, freed, frame_evt;

  // both banks share one array; the top address bit selects the bank
  logic [DW-1:0] mem [0:(2**(AW+1))-1];

  function automatic logic writable(bank_st_e s);
    return (s == ST_EMPTY) || (s == ST_FILLING);
  endfunction

  // next-state: RX write, then tx_start/tx_done, then rx_done (so a freed bank can take the frame)
  always_comb begin
    st_d      = st_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    noroom_d  = noroom_q;
    dlen_d    = dlen_q;
    tlen_d    = tlen_q;
    drop_d    = 1'b0;
    freed     = 1'b0;
    frame_evt = 1'b0;
    wr_ok     = writable(st_q[wr_bank_q]);
    wr_en     = bus.rx_valid && wr_ok;

    if (bus.rx_valid) begin
      if (wr_ok) begin
        if (st_q[wr_bank_q] == ST_EMPTY) st_d[wr_bank_q] = ST_FILLING;
      end else begin
        noroom_d = 1'b1;
      end
    end

    if (bus.tx_start && tx_req_q && st_q[rd_bank_q] == ST_FULL)
      st_d[rd_bank_q] = ST_SENDING;

    if (bus.tx_done && st_q[rd_bank_q] == ST_SENDING) begin
      st_d[rd_bank_q] = ST_EMPTY;
      rd_bank_d       = ~rd_bank_q;
      freed           = 1'b1;
      // writer parked on an occupied bank jumps to the one just released
      if (!writable(st_d[wr_bank_q])) wr_bank_d = rd_bank_q;
    end

    if (bus.rx_done) begin
      noroom_d = 1'b0;
      if (writable(st_d[wr_bank_d])) begin
        // a bank freed this very cycle overrides a pending no-room error
        if (bus.rx_data_length < 16'(MIN_LEN) ||
            ((noroom_q || (bus.rx_valid && !wr_ok)) && !freed)) begin
          drop_d            = 1'b1;
          st_d[wr_bank_d]   = ST_EMPTY;
        end else begin
          st_d[wr_bank_d]   = ST_FULL;
          dlen_d[wr_bank_d] = bus.rx_data_length;
          tlen_d[wr_bank_d] = bus.rx_total_length;
          frame_evt         = 1'b1;
          if (st_d[~wr_bank_d] == ST_EMPTY) wr_bank_d = ~wr_bank_d;
        end
      end else begin
        drop_d = 1'b1;
      end
    end

    tx_req_d  = (st_d[rd_bank_d] == ST_FULL);
    tx_dlen_d = dlen_d[rd_bank_d];
    tx_tlen_d = tlen_d[rd_bank_d];
  end

  // control state and registered TX-facing outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= '{ST_EMPTY, ST_EMPTY};
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      noroom_q  <= 1'b0;
      dlen_q    <= '{16'd0, 16'd0};
      tlen_q    <= '{16'd0, 16'd0};
      tx_req_q  <= 1'b0;
      tx_dlen_q <= 16'd0;
      tx_tlen_q <= 16'd0;
      drop_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      noroom_q  <= noroom_d;
      dlen_q    <= dlen_d;
      tlen_q    <= tlen_d;
      tx_req_q  <= tx_req_d;
      tx_dlen_q <= tx_dlen_d;
      tx_tlen_q <= tx_tlen_d;
      drop_q    <= drop_d;
    end
  end

  // payload RAM write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank_q, bus.rx_addr}] <= bus.rx_data;
  end

  // registered read port on the TX bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= mem[{rd_bank_q, bus.rd_addr}];
  end

  assign bus.rd_data         = rd_data_q;
  assign bus.tx_req          = tx_req_q;
  assign bus.tx_data_length  = tx_dlen_q;
  assign bus.tx_total_length = tx_tlen_q;
  assign bus.drop_pulse      = drop_q;

`ifdef M_UDP_BUF_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // saturating counters for accepted and dropped frames
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (frame_evt && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
    if (drop_d    && drop_cnt_q  != 16'hFFFF) drop_cnt_d  = drop_cnt_q + 16'd1;
  end

  // counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_m_udp_pingpong_buf.sv
// Directed bench for the UDP ping-pong buffer: reset, single frame,
// ping-pong ordering, overrun, short frame, simultaneous done, mid-frame reset.
module tb_m_udp_pingpong_buf;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  m_udp_pingpong_buf_if #(.AW(AW), .DW(DW)) bus ();

`ifdef M_UDP_BUF_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
  m_udp_pingpong_buf #(.AW(AW), .DW(DW), .MIN_LEN(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt));
`else
  m_udp_pingpong_buf #(.AW(AW), .DW(DW), .MIN_LEN(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n payload words base+i (or base*(i+1) when mul set), then rx_done; optional tx_done on the done cycle
  task automatic send_frame(input logic [31:0] base, input int n, input logic mul,
                            input logic [15:0] len, input logic [15:0] tot,
                            input logic with_tx_done);
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_addr  = AW'(i);
      bus.rx_data  = mul ? base * (i + 1) : base + i;
      tick();
    end
    bus.rx_valid        = 1'b0;
    bus.rx_done         = 1'b1;
    bus.rx_data_length  = len;
    bus.rx_total_length = tot;
    bus.tx_done         = with_tx_done;
    tick();
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
  endtask

  task automatic pulse_start();
    bus.tx_start = 1'b1; tick(); bus.tx_start = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    total++; if (bus.tx_req !== 1'b0) begin bad++; $display("FAIL reset_tx_req got=%h exp=0", bus.tx_req); end
    total++; if (bus.drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_drop got=%h exp=0", bus.drop_pulse); end
    total++; if (bus.rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
    total++; if (bus.tx_data_length !== 16'd0 || bus.tx_total_length !== 16'd0) begin
      bad++; $display("FAIL reset_len got=%0d/%0d exp=0/0", bus.tx_data_length, bus.tx_total_length); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    send_frame(32'h11111111, 4, 1'b1, 16'd24, 16'd44, 1'b0);
    total++; if (bus.tx_req !== 1'b1) begin bad++; $display("FAIL single_tx_req got=%h exp=1", bus.tx_req); end
    total++; if (bus.tx_data_length !== 16'd24 || bus.tx_total_length !== 16'd44) begin
      bad++; $display("FAIL single_len got=%0d/%0d exp=24/44", bus.tx_data_length, bus.tx_total_length); end
    total++; if (bus.drop_pulse !== 1'b0) begin bad++; $display("FAIL single_drop got=%h exp=0", bus.drop_pulse); end
    bus.rd_addr = 9'd2;
    tick();
    total++; if (bus.rd_data !== 32'h33333333) begin bad++; $display("FAIL single_rd got=%h exp=33333333", bus.rd_data); end
    pulse_start();
    total++; if (bus.tx_req !== 1'b0) begin bad++; $display("FAIL single_sending_req got=%h exp=0", bus.tx_req); end
    pulse_done();
  endtask

  task automatic test_pingpong();
    send_frame(32'hA0000000, 3, 1'b0, 16'd16, 16'd36, 1'b0);
    send_frame(32'hB0000000, 5, 1'b0, 16'd20, 16'd40, 1'b0);
    total++; if (bus.tx_req !== 1'b1 || bus.tx_data_length !== 16'd16) begin
      bad++; $display("FAIL pp_first req=%h len=%0d exp 1/16", bus.tx_req, bus.tx_data_length); end
    pulse_start();
    pulse_done();
    total++; if (bus.tx_req !== 1'b1 || bus.tx_data_length !== 16'd20 || bus.tx_total_length !== 16'd40) begin
      bad++; $display("FAIL pp_second req=%h len=%0d/%0d exp 1/20/40", bus.tx_req, bus.tx_data_length, bus.tx_total_length); end
  endtask

  task automatic test_overrun();
    send_frame(32'hC0000000, 4, 1'b0, 16'd28, 16'd48, 1'b0);
    total++; if (bus.drop_pulse !== 1'b0) begin bad++; $display("FAIL ovr_c_drop got=%h exp=0", bus.drop_pulse); end
    send_frame(32'hF0000000, 3, 1'b0, 16'd32, 16'd52, 1'b0);
    total++; if (bus.drop_pulse !== 1'b1) begin bad++; $display("FAIL ovr_drop got=%h exp=1", bus.drop_pulse); end
    bus.rd_addr = 9'd1;
    tick();
    total++; if (bus.drop_pulse !== 1'b0) begin bad++; $display("FAIL ovr_drop_once got=%h exp=0", bus.drop_pulse); end
    total++; if (bus.tx_req !== 1'b1 || bus.tx_data_length !== 16'd20) begin
      bad++; $display("FAIL ovr_state req=%h len=%0d exp 1/20", bus.tx_req, bus.tx_data_length); end
    total++; if (bus.rd_data !== 32'hB0000001) begin bad++; $display("FAIL ovr_rd got=%h exp=b0000001", bus.rd_data); end
  endtask

  task automatic test_simultaneous();
    pulse_start();
    send_frame(32'hD0000000, 2, 1'b0, 16'd12, 16'd32, 1'b1);
    total++; if (bus.drop_pulse !== 1'b0) begin bad++; $display("FAIL sim_drop got=%h exp=0", bus.drop_pulse); end
    total++; if (bus.tx_req !== 1'b1 || bus.tx_data_length !== 16'd28) begin
      bad++; $display("FAIL sim_next req=%h len=%0d exp 1/28", bus.tx_req, bus.tx_data_length); end
    bus.rd_addr = 9'd0;
    tick();
    total++; if (bus.rd_data !== 32'hC0000000) begin bad++; $display("FAIL sim_c_intact got=%h exp=c0000000", bus.rd_data); end
    pulse_start();
    pulse_done();
    total++; if (bus.tx_req !== 1'b1 || bus.tx_data_length !== 16'd12 || bus.tx_total_length !== 16'd32) begin
      bad++; $display("FAIL sim_kept req=%h len=%0d/%0d exp 1/12/32", bus.tx_req, bus.tx_data_length, bus.tx_total_length); end
    pulse_start();
    pulse_done();
    total++; if (bus.tx_req !== 1'b0) begin bad++; $display("FAIL sim_drained got=%h exp=0", bus.tx_req); end
  endtask

  task automatic test_short();
    send_frame(32'h55555555, 1, 1'b0, 16'd6, 16'd26, 1'b0);
    total++; if (bus.drop_pulse !== 1'b1 || bus.tx_req !== 1'b0) begin
      bad++; $display("FAIL short drop=%h req=%h exp 1/0", bus.drop_pulse, bus.tx_req); end
    pulse_start();
    total++; if (bus.tx_req !== 1'b0 || bus.drop_pulse !== 1'b0) begin
      bad++; $display("FAIL short_after req=%h drop=%h exp 0/0", bus.tx_req, bus.drop_pulse); end
    send_frame(32'h0, 0, 1'b0, 16'd8, 16'd28, 1'b0);
    total++; if (bus.tx_req !== 1'b1 || bus.tx_data_length !== 16'd8 || bus.drop_pulse !== 1'b0) begin
      bad++; $display("FAIL hdr_only req=%h len=%0d drop=%h exp 1/8/0", bus.tx_req, bus.tx_data_length, bus.drop_pulse); end
    pulse_start();
    pulse_done();
  endtask

  task automatic test_reset_mid();
`ifdef M_UDP_BUF_STATS_EN
    total++; if (frame_cnt !== 16'd6 || drop_cnt !== 16'd2) begin
      bad++; $display("FAIL stats_pre frame=%0d drop=%0d exp 6/2", frame_cnt, drop_cnt); end
`endif
    for (int i = 0; i < 2; i++) begin
      bus.rx_valid = 1'b1; bus.rx_addr = AW'(i); bus.rx_data = 32'h77770000 + i;
      tick();
    end
    bus.rx_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    total++; if (bus.tx_req !== 1'b0 || bus.tx_data_length !== 16'd0 || bus.tx_total_length !== 16'd0) begin
      bad++; $display("FAIL midrst req=%h len=%0d/%0d exp 0/0/0", bus.tx_req, bus.tx_data_length, bus.tx_total_length); end
`ifdef M_UDP_BUF_STATS_EN
    total++; if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      bad++; $display("FAIL stats_rst frame=%0d drop=%0d exp 0/0", frame_cnt, drop_cnt); end
`endif
    tick();
    reset_n = 1'b1;
    tick();
    send_frame(32'hE0000000, 3, 1'b0, 16'd40, 16'd60, 1'b0);
    total++; if (bus.tx_req !== 1'b1 || bus.tx_data_length !== 16'd40 || bus.tx_total_length !== 16'd60) begin
      bad++; $display("FAIL post_rst req=%h len=%0d/%0d exp 1/40/60", bus.tx_req, bus.tx_data_length, bus.tx_total_length); end
    bus.rd_addr = 9'd1;
    tick();
    total++; if (bus.rd_data !== 32'hE0000001) begin bad++; $display("FAIL post_rst_rd got=%h exp=e0000001", bus.rd_data); end
`ifdef M_UDP_BUF_STATS_EN
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL stats_post frame=%0d exp 1", frame_cnt); end
`endif
  endtask

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_addr = '0; bus.rx_done = 1'b0;
    bus.rx_data_length = '0; bus.rx_total_length = '0; bus.rd_addr = '0;
    bus.tx_start = 1'b0; bus.tx_done = 1'b0;
    test_reset();
    test_single();
    test_pingpong();
    test_overrun();
    test_simultaneous();
    test_short();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
